vga_sprite_layer: RTL and testbench

Parametrised multi-sprite compositor for the 640x480 VGA pipeline. It sits between the timing generator and the colour output. It overlays NUM_SPRITES 1-bit sprites, each with its own position and visibility, on a background pixel stream. Each sprite's ROM address is computed directly from the pixel position, not from a running offset counter. Position updates are double-buffered so they take effect only at frame boundaries, and the block reports sprite-0 collisions once per frame.

---
 rtl/vga_sprite_layer.sv | 178 +++++++++++++++++
 tb/tb_vga_sprite_layer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_layer.sv
// Multi-sprite overlay for the 640x480 VGA pixel stream: double-buffered sprite positions,
// two-strobe compositing pipeline and per-frame sprite-0 collision reporting.
module vga_sprite_layer #(
   parameter int unsigned NUM_SPRITES   = 4,
   parameter int unsigned SPRITE_W      = 60,
   parameter int unsigned SPRITE_H      = 60,
   parameter int unsigned ROM_ADDR_BITS = 12,
   parameter int unsigned COLOR_BITS    = 12,
   parameter logic [COLOR_BITS-1:0] FG_COLOR = '0,
   localparam int unsigned SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  pix_en,
   input  logic                                  active,
   input  logic                                  screen_end,
   input  logic [9:0]                            x,
   input  logic [8:0]                            y,
   input  logic [COLOR_BITS-1:0]                 bg_color,
   input  logic                                  wr_en,
   input  logic [SEL_W-1:0]                      wr_sel,
   input  logic [9:0]                            wr_x,
   input  logic [8:0]                            wr_y,
   input  logic                                  wr_vis,
   output logic [NUM_SPRITES*ROM_ADDR_BITS-1:0]  rom_addr,
   input  logic [NUM_SPRITES-1:0]                rom_data,
   output logic [COLOR_BITS-1:0]                 color_out,
   output logic [NUM_SPRITES-1:0]                hit_mask,
   output logic                                  collision,
   output logic [15:0]                           frame_cnt
);

   logic frame_tick;
   assign frame_tick = pix_en & screen_end;

   // Shadow and live sprite registers
   logic [9:0]             sh_x_q [NUM_SPRITES];
   logic [9:0]             sh_x_d [NUM_SPRITES];
   logic [8:0]             sh_y_q [NUM_SPRITES];
   logic [8:0]             sh_y_d [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] sh_vis_q, sh_vis_d;
   logic [9:0]             lv_x_q [NUM_SPRITES];
   logic [8:0]             lv_y_q [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] lv_vis_q;

   always_comb begin
      sh_x_d   = sh_x_q;
      sh_y_d   = sh_y_q;
      sh_vis_d = sh_vis_q;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (wr_en && (int'(wr_sel) == i)) begin
            sh_x_d[i]   = wr_x;
            sh_y_d[i]   = wr_y;
            sh_vis_d[i] = wr_vis;
         end
      end
   end

   // Live copy is taken from the post-write shadow value so a write on the frame tick lands
   // in the frame that is about to start.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            sh_x_q[i] <= '0;
            sh_y_q[i] <= '0;
            lv_x_q[i] <= '0;
            lv_y_q[i] <= '0;
         end
         sh_vis_q <= '0;
         lv_vis_q <= '0;
      end else begin
         sh_x_q   <= sh_x_d;
         sh_y_q   <= sh_y_d;
         sh_vis_q <= sh_vis_d;
         if (frame_tick) begin
            lv_x_q   <= sh_x_d;
            lv_y_q   <= sh_y_d;
            lv_vis_q <= sh_vis_d;
         end
      end
   end

   // Stage A: bounding-box test and direct ROM address
   logic [NUM_SPRITES-1:0]                    inside_a;
   logic [NUM_SPRITES-1:0][ROM_ADDR_BITS-1:0] addr_a;

   always_comb begin
      logic [10:0] x_lo, x_hi, x_pix;
      logic [9:0]  y_lo, y_hi, y_pix;
      logic [9:0]  dx;
      logic [8:0]  dy;
      logic [31:0] addr_full;
      inside_a = '0;
      addr_a   = '0;
      x_pix    = {1'b0, x};
      y_pix    = {1'b0, y};
      for (int i = 0; i < NUM_SPRITES; i++) begin
         // One extra bit keeps sprites hanging off the right/bottom edge from wrapping to 0.
         x_lo      = {1'b0, lv_x_q[i]};
         x_hi      = x_lo + 11'(SPRITE_W);
         y_lo      = {1'b0, lv_y_q[i]};
         y_hi      = y_lo + 10'(SPRITE_H);
         dx        = x - lv_x_q[i];
         dy        = y - lv_y_q[i];
         addr_full = 32'(dy) * SPRITE_W + 32'(dx);
         inside_a[i] = lv_vis_q[i] && (x_pix >= x_lo) && (x_pix < x_hi)
                       && (y_pix >= y_lo) && (y_pix < y_hi);
         addr_a[i] = inside_a[i] ? addr_full[ROM_ADDR_BITS-1:0] : '0;
      end
   end

   logic [NUM_SPRITES-1:0][ROM_ADDR_BITS-1:0] rom_addr_q;
   logic [NUM_SPRITES-1:0]                    inside_q;
   logic [COLOR_BITS-1:0]                     bg_q;
   logic                                      active_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         rom_addr_q <= '0;
         inside_q   <= '0;
         bg_q       <= '0;
         active_q   <= 1'b0;
      end else if (pix_en) begin
         rom_addr_q <= addr_a;
         inside_q   <= inside_a;
         bg_q       <= bg_color;
         active_q   <= active;
      end
   end

   assign rom_addr = rom_addr_q;

   // Stage B: compositing. Every sprite draws FG_COLOR, so lowest-index priority reduces to
   // "any opaque sprite wins over the background".
   logic [NUM_SPRITES-1:0] opaque;
   logic [COLOR_BITS-1:0]  color_d, color_q;
   logic [NUM_SPRITES-1:0] hit_d, hit_q;
   logic                   coll_term;
   logic                   coll_acc_q, collision_q;
   logic [15:0]            frame_cnt_q;

   always_comb begin
      opaque    = inside_q & rom_data;
      color_d   = '0;
      hit_d     = '0;
      if (active_q) begin
         color_d = (|opaque) ? FG_COLOR : bg_q;
         hit_d   = opaque;
      end
      coll_term = active_q & opaque[0] & (|(opaque >> 1));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         color_q     <= '0;
         hit_q       <= '0;
         coll_acc_q  <= 1'b0;
         collision_q <= 1'b0;
         frame_cnt_q <= '0;
      end else if (pix_en) begin
         color_q <= color_d;
         hit_q   <= hit_d;
         if (screen_end) begin
            collision_q <= coll_acc_q | coll_term;
            coll_acc_q  <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end else begin
            coll_acc_q <= coll_acc_q | coll_term;
         end
      end
   end

   assign color_out = color_q;
   assign hit_mask  = hit_q;
   assign collision = collision_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_sprite_layer.sv
// Directed bench for vga_sprite_layer: reset, addressing/clipping/priority vector table,
// then hand sequences for double buffering, collision reporting and frame counter wrap.
module tb_vga_sprite_layer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        pix_en = 1'b0;
   logic        active = 1'b0;
   logic        screen_end = 1'b0;
   logic [9:0]  x = '0;
   logic [8:0]  y = '0;
   logic [11:0] bg_color = '0;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_sel = '0;
   logic [9:0]  wr_x = '0;
   logic [8:0]  wr_y = '0;
   logic        wr_vis = 1'b0;
   logic [47:0] rom_addr;
   logic [3:0]  rom_data = '0;
   logic [11:0] color_out;
   logic [3:0]  hit_mask;
   logic        collision;
   logic [15:0] frame_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   vga_sprite_layer #(
      .NUM_SPRITES(4),
      .FG_COLOR   (12'hF00)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pix_en    (pix_en),
      .active    (active),
      .screen_end(screen_end),
      .x         (x),
      .y         (y),
      .bg_color  (bg_color),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_x      (wr_x),
      .wr_y      (wr_y),
      .wr_vis    (wr_vis),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .color_out (color_out),
      .hit_mask  (hit_mask),
      .collision (collision),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  px;
      logic [8:0]  py;
      logic        act;
      logic [11:0] bg;
      logic [3:0]  rd;     // rom_data for the previous pixel's stage B
      logic [47:0] addr;   // {a3,a2,a1,a0} for this pixel
      logic [11:0] color;  // previous pixel
      logic [3:0]  hit;    // previous pixel
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   // One pixel strobe followed by an idle clock; returns at the negedge after the strobe edge.
   task automatic strobe(input logic [9:0] px, input logic [8:0] py, input logic act,
                         input logic se, input logic [11:0] bg, input logic [3:0] rd);
      @(negedge clk);
      x = px; y = py; active = act; screen_end = se; bg_color = bg; rom_data = rd;
      pix_en = 1'b1;
      @(negedge clk);
      pix_en = 1'b0;
      screen_end = 1'b0;
   endtask

   task automatic write_sprite(input logic [1:0] sel, input logic [9:0] wx, input logic [8:0] wy,
                               input logic v);
      @(negedge clk);
      wr_en = 1'b1; wr_sel = sel; wr_x = wx; wr_y = wy; wr_vis = v;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   initial begin
      vecs[0] = '{10'd31,  9'd276, 1'b1, 12'hABC, 4'b0000,
                  {12'd0, 12'd0, 12'd0, 12'd61},      12'h000, 4'b0000};
      vecs[1] = '{10'd89,  9'd334, 1'b1, 12'h123, 4'b0001,
                  {12'd0, 12'd3289, 12'd0, 12'd3599}, 12'hF00, 4'b0001};
      vecs[2] = '{10'd90,  9'd276, 1'b1, 12'h456, 4'b0101,
                  {12'd0, 12'd0, 12'd0, 12'd0},       12'hF00, 4'b0101};
      vecs[3] = '{10'd639, 9'd479, 1'b1, 12'h789, 4'b1111,
                  {12'd0, 12'd0, 12'd559, 12'd0},     12'h456, 4'b0000};
      vecs[4] = '{10'd0,   9'd479, 1'b1, 12'h111, 4'b0000,
                  {12'd0, 12'd0, 12'd0, 12'd0},       12'h789, 4'b0000};
      vecs[5] = '{10'd50,  9'd300, 1'b0, 12'h222, 4'b0000,
                  {12'd0, 12'd1210, 12'd0, 12'd1520}, 12'h111, 4'b0000};
      vecs[6] = '{10'd60,  9'd290, 1'b1, 12'h333, 4'b0101,
                  {12'd0, 12'd620, 12'd0, 12'd930},   12'h000, 4'b0000};
      vecs[7] = '{10'd60,  9'd290, 1'b1, 12'h444, 4'b0000,
                  {12'd0, 12'd620, 12'd0, 12'd930},   12'h333, 4'b0000};
      vecs[8] = '{10'd0,   9'd0,   1'b0, 12'h000, 4'b0100,
                  {12'd0, 12'd0, 12'd0, 12'd0},       12'hF00, 4'b0100};

      // Reset held with conflicting write and frame strobes
      reset = 1'b0; wr_en = 1'b1; wr_sel = 2'd0; wr_vis = 1'b1;
      pix_en = 1'b1; screen_end = 1'b1; active = 1'b1; rom_data = 4'hF; bg_color = 12'hFFF;
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b1; wr_en = 1'b0; pix_en = 1'b0; screen_end = 1'b0; active = 1'b0;
      check("reset rom_addr", rom_addr, 0);
      check("reset color_out", color_out, 0);
      check("reset hit_mask", hit_mask, 0);
      check("reset collision", collision, 0);
      check("reset frame_cnt", frame_cnt, 0);

      // Frame after reset: write during reset was dropped, so only background shows
      strobe(0, 0, 1'b0, 1'b1, 12'h000, 4'b0000);
      strobe(0, 0, 1'b1, 1'b0, 12'hABC, 4'b0000);
      strobe(1, 0, 1'b1, 1'b0, 12'h000, 4'b1111);
      check("post-reset bg color", color_out, 12'hABC);
      check("post-reset bg hit", hit_mask, 4'b0000);
      check("post-reset frame_cnt", frame_cnt, 1);

      // Sprite setup; sprite 3 sits on the probe pixel but is invisible
      write_sprite(2'd0, 10'd30,  9'd275, 1'b1);
      write_sprite(2'd1, 10'd620, 9'd470, 1'b1);
      write_sprite(2'd2, 10'd40,  9'd280, 1'b1);
      write_sprite(2'd3, 10'd60,  9'd290, 1'b0);
      strobe(0, 0, 1'b0, 1'b1, 12'h000, 4'b0000);
      check("setup frame_cnt", frame_cnt, 2);
      check("setup collision", collision, 0);

      for (int i = 0; i < 9; i++) begin
         strobe(vecs[i].px, vecs[i].py, vecs[i].act, 1'b0, vecs[i].bg, vecs[i].rd);
         check($sformatf("vec%0d rom_addr", i), rom_addr, vecs[i].addr);
         check($sformatf("vec%0d color_out", i), color_out, vecs[i].color);
         check($sformatf("vec%0d hit_mask", i), hit_mask, vecs[i].hit);
      end

      // The overlap seen in vector 2 is reported at the frame boundary
      strobe(0, 0, 1'b0, 1'b1, 12'h000, 4'b0000);
      check("frame1 collision", collision, 1);
      check("frame1 frame_cnt", frame_cnt, 3);

      // Frame with sprites co-located but transparent: no collision
      strobe(60, 290, 1'b1, 1'b0, 12'h333, 4'b0000);
      strobe(0, 0, 1'b0, 1'b1, 12'h000, 4'b0000);
      check("frame2 collision", collision, 0);
      check("frame2 frame_cnt", frame_cnt, 4);

      // Overlap on the frame-boundary strobe itself still counts for that frame
      strobe(60, 290, 1'b1, 1'b0, 12'h333, 4'b0000);
      strobe(0, 0, 1'b0, 1'b1, 12'h000, 4'b0101);
      check("boundary collision", collision, 1);
      check("boundary hit_mask", hit_mask, 4'b0101);
      check("boundary frame_cnt", frame_cnt, 5);

      // Reset mid-frame discards the pending collision
      strobe(60, 290, 1'b1, 1'b0, 12'h333, 4'b0000);
      strobe(0, 0, 1'b0, 1'b0, 12'h000, 4'b0101);
      check("pre-reset hit_mask", hit_mask, 4'b0101);
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
      strobe(0, 0, 1'b0, 1'b1, 12'h000, 4'b0000);
      check("mid-reset collision", collision, 0);
      check("mid-reset frame_cnt", frame_cnt, 1);

      // Double buffering
      write_sprite(2'd0, 10'd30, 9'd275, 1'b1);
      strobe(0, 0, 1'b0, 1'b1, 12'h000, 4'b0000);
      write_sprite(2'd0, 10'd100, 9'd275, 1'b1);
      strobe(31, 276, 1'b1, 1'b0, 12'h5A5, 4'b0000);
      check("dbuf old position addr", rom_addr, 48'd61);
      strobe(0, 0, 1'b0, 1'b0, 12'h000, 4'b0001);
      check("dbuf old position color", color_out, 12'hF00);
      check("dbuf old position hit", hit_mask, 4'b0001);
      @(negedge clk);
      x = 0; y = 0; active = 1'b0; rom_data = 4'b0000;
      pix_en = 1'b1; screen_end = 1'b1;
      wr_en = 1'b1; wr_sel = 2'd0; wr_x = 10'd200; wr_y = 9'd275; wr_vis = 1'b1;
      @(negedge clk);
      pix_en = 1'b0; screen_end = 1'b0; wr_en = 1'b0;
      check("dbuf frame_cnt", frame_cnt, 3);
      strobe(101, 276, 1'b1, 1'b0, 12'h0F0, 4'b0000);
      check("dbuf stale x addr", rom_addr, 48'd0);
      strobe(201, 276, 1'b1, 1'b0, 12'h0F0, 4'b0001);
      check("dbuf same-strobe write addr", rom_addr, 48'd61);
      check("dbuf stale x color", color_out, 12'h0F0);
      check("dbuf stale x hit", hit_mask, 4'b0000);

      // Frame counter wrap; strobing every clock here only to keep the run short
      @(negedge clk);
      x = 0; y = 0; active = 1'b0; rom_data = 4'b0000;
      pix_en = 1'b1; screen_end = 1'b1;
      repeat (65532) @(negedge clk);
      pix_en = 1'b0; screen_end = 1'b0;
      check("frame_cnt max", frame_cnt, 16'hFFFF);
      strobe(0, 0, 1'b0, 1'b1, 12'h000, 4'b0000);
      check("frame_cnt wrap", frame_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
